// File: rtl/wb_pipe.sv
// rtl/wb_pipe.sv - write-back stage: source mux, output register plus skid entry, bypass and write counter
module wb_pipe #(
  parameter int DATA_W  = 8,
  parameter int RD_W    = 2,
  parameter int ZERO_RO = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WR,
  input  logic [1:0]        RM,
  input  logic [DATA_W-1:0] ACOUT,
  input  logic [DATA_W-1:0] MEMOUT,
  input  logic [DATA_W-1:0] IMM,
  input  logic [DATA_W-1:0] LINK,
  input  logic [RD_W-1:0]   rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic              WROut,
  output logic [RD_W-1:0]   rdOut,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   or_data_q, or_data_d, sk_data_q, sk_data_d;
  logic                or_we_q, or_we_d, sk_we_q, sk_we_d;
  logic [RD_W-1:0]     or_rd_q, or_rd_d, sk_rd_q, sk_rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_we;
  logic                accept, retire;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign data      = or_data_q;
  assign WROut     = or_we_q;
  assign rdOut     = or_rd_q;
  assign wr_count  = cnt_q;

  always_comb begin
    sel_data = ACOUT;
    case (RM)
      2'd0:    sel_data = ACOUT;
      2'd1:    sel_data = MEMOUT;
      2'd2:    sel_data = IMM;
      default: sel_data = LINK;
    endcase
    sel_we = WR && !((ZERO_RO != 0) && (rd == '0));
  end

  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    or_we_d   = or_we_q;
    or_rd_d   = or_rd_q;
    sk_data_d = sk_data_q;
    sk_we_d   = sk_we_q;
    sk_rd_d   = sk_rd_q;
    cnt_d     = cnt_q;
    if (retire && or_we_q) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      EMPTY: begin
        if (accept) begin
          or_data_d = sel_data;
          or_we_d   = sel_we;
          or_rd_d   = rd;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && retire) begin
          or_data_d = sel_data;
          or_we_d   = sel_we;
          or_rd_d   = rd;
        end else if (accept) begin
          sk_data_d = sel_data;
          sk_we_d   = sel_we;
          sk_rd_d   = rd;
          state_d   = TWO;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // skid entry is always the younger beat, so it drains into OR on retire
        if (retire) begin
          or_data_d = sk_data_q;
          or_we_d   = sk_we_q;
          or_rd_d   = sk_rd_q;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (state_q == TWO) begin
      fwd_valid = sk_we_q;
      fwd_rd    = sk_rd_q;
      fwd_data  = sk_data_q;
    end else if (state_q == ONE) begin
      fwd_valid = or_we_q;
      fwd_rd    = or_rd_q;
      fwd_data  = or_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      or_data_q <= '0;
      or_we_q   <= 1'b0;
      or_rd_q   <= '0;
      sk_data_q <= '0;
      sk_we_q   <= 1'b0;
      sk_rd_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      or_data_q <= or_data_d;
      or_we_q   <= or_we_d;
      or_rd_q   <= or_rd_d;
      sk_data_q <= sk_data_d;
      sk_we_q   <= sk_we_d;
      sk_rd_q   <= sk_rd_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
